// File: rtl/lcd_spi_stream_writer.sv
// Multi-requester LCD SPI writer: packet-locked arbiter, word FIFO, and mode-0 serialiser.
// Define LCD_SPI_RR_EN for round-robin arbitration; the default is fixed priority (lowest index wins).
module lcd_spi_stream_writer #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int CS_GAP     = 2
) (
    input  logic                             sys_clk,
    input  logic                             sys_rst,
    input  logic [NUM_CH*(DATA_W+1)-1:0]     ch_data,
    input  logic [NUM_CH-1:0]                ch_valid,
    input  logic [NUM_CH-1:0]                ch_last,
    output logic [NUM_CH-1:0]                ch_ready,
    output logic                             lcd_cs,
    output logic                             lcd_dc,
    output logic                             lcd_sclk,
    output logic                             lcd_mosi,
    output logic                             word_done,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic                             busy
);

    localparam int WORD_W = DATA_W + 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP} state_t;

    logic              locked;
    logic [GW-1:0]     grant;
    logic [GW-1:0]     pick;
    logic              any_valid;
    logic [WORD_W-1:0] push_word;
    logic              push_last;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] rd_word;

`ifdef LCD_SPI_RR_EN
    logic [GW-1:0]     rr_ptr;

    // Search begins one past the previous winner so every requester gets a turn.
    always_comb begin : pick_rr
        int  idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && ch_valid[idx]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin : pick_fixed
        pick = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_valid[i]) pick = GW'(i);
        end
    end
`endif

    assign any_valid = |ch_valid;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        push_word = '0;
        push_last = 1'b0;
        ch_ready  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == GW'(i)) begin
                push_word   = ch_data[i*WORD_W +: WORD_W];
                push_last   = ch_last[i];
                ch_ready[i] = locked && !fifo_full;
            end
        end
    end

    assign push = |(ch_valid & ch_ready);

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            locked <= 1'b0;
            grant  <= '0;
`ifdef LCD_SPI_RR_EN
            rr_ptr <= '0;
`endif
        end else if (!locked) begin
            if (any_valid) begin
                locked <= 1'b1;
                grant  <= pick;
`ifdef LCD_SPI_RR_EN
                rr_ptr <= (pick == GW'(NUM_CH - 1)) ? '0 : pick + 1'b1;
`endif
            end
        end else if (push && push_last) begin
            locked <= 1'b0;
        end
    end

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // NOTE: storage has no reset; validity is tracked entirely by the pointers and level.
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign fifo_full  = (fifo_level == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_level == '0);
    assign rd_word    = mem[rd_ptr];

    state_t            state;
    state_t            state_d;
    logic              last_fall;
    logic              div_done;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] shreg;

    assign div_done = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_d   = state;
        pop       = 1'b0;
        last_fall = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (div_done) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // The falling edge that ends the final bit either chains the next word or closes the burst.
                if (div_done && lcd_sclk && (bit_cnt == BIT_W'(DATA_W - 1))) begin
                    last_fall = 1'b1;
                    if (!fifo_empty) pop = 1'b1;
                    else             state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(CS_GAP - 1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= S_IDLE;
        else         state <= state_d;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lcd_cs    <= 1'b1;
            lcd_dc    <= 1'b0;
            lcd_sclk  <= 1'b0;
            word_done <= 1'b0;
            shreg     <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            word_done <= last_fall;
            case (state)
                S_IDLE: begin
                    lcd_cs   <= 1'b1;
                    lcd_sclk <= 1'b0;
                    div_cnt  <= '0;
                    if (pop) begin
                        shreg  <= rd_word[DATA_W-1:0];
                        lcd_dc <= rd_word[DATA_W];
                        lcd_cs <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (div_done) begin
                        div_cnt  <= '0;
                        lcd_sclk <= 1'b1;
                        bit_cnt  <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (div_done) begin
                        div_cnt  <= '0;
                        lcd_sclk <= ~lcd_sclk;
                        if (lcd_sclk) begin
                            if (last_fall) begin
                                bit_cnt <= '0;
                                if (pop) begin
                                    shreg  <= rd_word[DATA_W-1:0];
                                    lcd_dc <= rd_word[DATA_W];
                                end else begin
                                    shreg   <= '0;
                                    lcd_cs  <= 1'b1;
                                    gap_cnt <= '0;
                                end
                            end else begin
                                shreg   <= shreg << 1;
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign lcd_mosi = shreg[DATA_W-1];
    assign busy     = !fifo_empty || (state != S_IDLE);

endmodule
